// File: rtl/gpio_hex_display.sv
// gpio_hex_display: consumer end of the CPU's 32-bit GPIO output port.
// The registered output word is converted to decimal with a serial
// shift-add-3 (double-dabble) engine and shown on active-low seven-segment
// digits. A conversion starts only when the word differs from the last
// converted one, so the CPU may rewrite the port at any rate.
// Optional macro HEX_BLANK_EN: blank leading zero digits (digit 0 is never
// blanked).
module gpio_hex_display #(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             value,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    logic [1:0]             state;
    logic [31:0]            value_q;
    logic [31:0]            last_conv;
    logic [31:0]            shift_reg;
    logic [39:0]            bcd_reg;
    logic [4:0]             count;
    logic                   valid;

    logic [71:0]            dd_next;
    logic [7*NUM_DIGITS-1:0] hex_next;
    logic                   overflow_next;
`ifdef HEX_BLANK_EN
    logic                   leading;
`endif

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal nibbles show "-".
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
    function automatic logic [39:0] add3(input logic [39:0] bcd);
        logic [39:0] res;
        res = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

    // One double-dabble step: adjust the BCD nibbles, then shift the pair left.
    always_comb begin
        dd_next = {add3(bcd_reg), shift_reg} << 1;
    end

    // Segment image and overflow flag derived from the finished BCD result.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        hex_next      = '1;
        overflow_next = 1'b0;
`ifdef HEX_BLANK_EN
        leading       = 1'b1;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hex_next[7*i +: 7] = seg_decode(bcd_reg[4*i +: 4]);
`ifdef HEX_BLANK_EN
            if (leading && i != 0 && bcd_reg[4*i +: 4] == 4'd0)
                hex_next[7*i +: 7] = 7'b1111111;
            else
                leading = 1'b0;
`endif
        end
        for (int i = 0; i < 10; i++) begin
            if (i >= NUM_DIGITS && bcd_reg[4*i +: 4] != 4'd0)
                overflow_next = 1'b1;
        end
    end

    // Input pipeline register: loads every cycle, reset or not.
    always_ff @(posedge clk) begin
        // NOTE: value_q is a plain data pipeline stage; leaving it out of
        // reset lets a word present during reset be converted right after.
        value_q <= value;
    end

    // Conversion FSM: capture on change, 32 shift steps, then display update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state     <= IDLE;
            hex_out   <= '1;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            count     <= 5'd0;
            valid     <= 1'b0;
            shift_reg <= 32'd0;
            bcd_reg   <= 40'd0;
            last_conv <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!valid || value_q != last_conv) begin
                        shift_reg <= value_q;
                        bcd_reg   <= 40'd0;
                        last_conv <= value_q;
                        count     <= 5'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_reg   <= dd_next[71:32];
                    shift_reg <= dd_next[31:0];
                    count     <= count + 5'd1;
                    if (count == 5'd31)
                        state <= UPDATE;
                end
                UPDATE: begin
                    hex_out  <= hex_next;
                    overflow <= overflow_next;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
